spm_operand_serializer: RTL and testbench

Parallel-to-serial operand front end for the signed 8x8 serial multiplier datapath. Accepts a pair of signed W-bit operands over a valid/ready handshake and drives them LSB-first, sign-extended to 2W bits, onto the `x`/`y` bit-serial inputs of the `carrySave` serial adder. Issues the one-cycle carry clear the adder needs before each new frame.

---
 rtl/spm_pkg.sv | 14 +
 rtl/spm_sext_shreg.sv | 29 ++
 rtl/spm_operand_serializer.sv | 122 ++++++++++++
 tb/tb_spm_operand_serializer.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spm_pkg.sv
// Shared definitions for the signed serial multiplier datapath: default operand
// width, serial frame length and the operand serializer state encoding.
package spm_pkg;

    localparam int SPM_W       = 8;
    localparam int SPM_OUT_LEN = 2 * SPM_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SHIFT = 2'd2
    } spm_state_t;

endpackage : spm_pkg

// File: rtl/spm_sext_shreg.sv
// Loadable W-bit arithmetic right shift register; the MSB is replicated on every
// shift, so the LSB output keeps producing the sign bit once the operand is spent.
module spm_sext_shreg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] d,
    output logic         lsb
);

    logic [W-1:0] q;

    // load wins over shift: a back-to-back accept reloads in the last-bit cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (shift) begin
            q <= {q[W-1], q[W-1:1]};
        end
    end

    assign lsb = q[0];

endmodule : spm_sext_shreg

// File: rtl/spm_operand_serializer.sv
// Parallel-to-serial operand front end: accepts a signed a/b pair and streams both
// LSB-first, sign-extended to OUT_LEN bits, preceded by a one-cycle carry clear.
module spm_operand_serializer
    import spm_pkg::*;
#(
    parameter int W       = SPM_W,
    parameter int OUT_LEN = SPM_OUT_LEN
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         en,
    output logic         x,
    output logic         y,
    output logic         csa_clr,
    output logic         frame_first,
    output logic         frame_last,
    output logic         busy,
    output logic [1:0]   fsm_state
);

    localparam int IDX_W = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OUT_LEN - 1);

    // Handshake: a pair transfers on a rising edge where in_valid && in_ready.
    // in_valid may be held across cycles; a/b are sampled only on that edge.
    // in_ready is high in IDLE, and in the last-bit SHIFT cycle when en is high.

    spm_state_t       state_q;
    spm_state_t       state_d;
    logic [IDX_W-1:0] idx_q;
    logic             last_bit;
    logic             accept;
    logic             shift;
    logic             sa_lsb;
    logic             sb_lsb;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        last_bit = (state_q == SHIFT) && (idx_q == IDX_LAST);

        case (state_q)
            IDLE:    in_ready = 1'b1;
            CLEAR:   in_ready = 1'b0;
            SHIFT:   in_ready = last_bit && en;
            default: in_ready = 1'b0;
        endcase

        accept = in_valid && in_ready;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                state_d = SHIFT;
            end
            SHIFT: begin
                if (last_bit && en) begin
                    state_d = accept ? CLEAR : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign shift = (state_q == SHIFT) && en;

    // idx saturates at the last bit; the frame-end transition takes over from there
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
        end else if (accept) begin
            idx_q <= '0;
        end else if (shift && !last_bit) begin
            idx_q <= idx_q + IDX_W'(1);
        end
    end

    spm_sext_shreg #(.W(W)) u_sreg_a (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .shift (shift),
        .d     (a),
        .lsb   (sa_lsb)
    );

    spm_sext_shreg #(.W(W)) u_sreg_b (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .shift (shift),
        .d     (b),
        .lsb   (sb_lsb)
    );

    assign x           = (state_q == SHIFT) && sa_lsb;
    assign y           = (state_q == SHIFT) && sb_lsb;
    assign csa_clr     = (state_q == CLEAR);
    assign frame_first = (state_q == SHIFT) && (idx_q == '0);
    assign frame_last  = last_bit;
    assign busy        = (state_q != IDLE);
    assign fsm_state   = state_q;

endmodule : spm_operand_serializer

// File: tb/tb_spm_operand_serializer.sv
// Directed bench for spm_operand_serializer: reset, single frame, back-to-back,
// stall, mid-frame reset and operand isolation, with hand-computed streams.
module tb_spm_operand_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       en;
    logic       x;
    logic       y;
    logic       csa_clr;
    logic       frame_first;
    logic       frame_last;
    logic       busy;
    logic [1:0] fsm_state;

    int checks   = 0;
    int failures = 0;

    spm_operand_serializer #(.W(8), .OUT_LEN(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .en          (en),
        .x           (x),
        .y           (y),
        .csa_clr     (csa_clr),
        .frame_first (frame_first),
        .frame_last  (frame_last),
        .busy        (busy),
        .fsm_state   (fsm_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; a = 8'h00; b = 8'h00; en = 1'b0;
        tick();
        in_valid = 1'b1; a = 8'h12; b = 8'h34;
        tick();
        checks++;
        if ({in_ready, busy, csa_clr, x, y, frame_first, frame_last} !== 7'b1000000) begin
            failures++;
            $display("FAIL reset_outputs: got %b want 1000000",
                     {in_ready, busy, csa_clr, x, y, frame_first, frame_last});
        end
        checks++;
        if (fsm_state !== 2'd0) begin
            failures++;
            $display("FAIL reset_state: got %0d want 0", fsm_state);
        end
        rst = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (csa_clr !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL reset_idle_%0d: clr=%b busy=%b rdy=%b want 0 0 1",
                         i, csa_clr, busy, in_ready);
            end
        end
    endtask

    task automatic test_basic_frame();
        logic [15:0] xs, ys, ffm, flm, sum;
        xs = '0; ys = '0; ffm = '0; flm = '0;
        in_valid = 1'b1; a = 8'hFD; b = 8'h05; en = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL basic_ready: got %b want 1", in_ready);
        end
        tick();
        in_valid = 1'b0; a = 8'h00; b = 8'h00;
        checks++;
        if ({csa_clr, busy, in_ready, x, y, frame_first} !== 6'b110000) begin
            failures++;
            $display("FAIL basic_clear: got %b want 110000",
                     {csa_clr, busy, in_ready, x, y, frame_first});
        end
        tick();
        checks++;
        if (csa_clr !== 1'b0 || frame_first !== 1'b1) begin
            failures++;
            $display("FAIL basic_clear_ignores_en: clr=%b first=%b want 0 1", csa_clr, frame_first);
        end
        en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            xs[i] = x; ys[i] = y; ffm[i] = frame_first; flm[i] = frame_last;
            tick();
        end
        checks++;
        if (xs !== 16'hFFFD) begin
            failures++;
            $display("FAIL basic_x_stream: got %h want fffd", xs);
        end
        checks++;
        if (ys !== 16'h0005) begin
            failures++;
            $display("FAIL basic_y_stream: got %h want 0005", ys);
        end
        checks++;
        if (ffm !== 16'h0001 || flm !== 16'h8000) begin
            failures++;
            $display("FAIL basic_markers: first=%h last=%h want 0001 8000", ffm, flm);
        end
        sum = xs + ys;
        checks++;
        if (sum !== 16'h0002) begin
            failures++;
            $display("FAIL basic_serial_sum: got %h want 0002", sum);
        end
        checks++;
        if ({busy, in_ready, csa_clr, x, y, frame_last} !== 6'b010000) begin
            failures++;
            $display("FAIL basic_end_idle: got %b want 010000",
                     {busy, in_ready, csa_clr, x, y, frame_last});
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] xs[2];
        logic [15:0] ys[2];
        int acc, busy_cyc, clr_cnt, fr, pos, n, acc_on_last;
        logic done;
        xs[0] = '0; xs[1] = '0; ys[0] = '0; ys[1] = '0;
        acc = 0; busy_cyc = 0; clr_cnt = 0; fr = -1; pos = 0; acc_on_last = 0; done = 1'b0;
        in_valid = 1'b1; a = 8'h7F; b = 8'h80; en = 1'b1;
        for (n = 0; n < 60 && !done; n++) begin
            if (busy) busy_cyc++;
            if (csa_clr) begin
                clr_cnt++; fr++; pos = 0;
            end else if (busy && fr >= 0 && fr < 2 && pos < 16) begin
                xs[fr][pos] = x; ys[fr][pos] = y; pos++;
            end
            if (in_valid && in_ready) begin
                acc++;
                if (acc == 2 && frame_last) acc_on_last = 1;
            end
            tick();
            if (acc == 1) begin
                a = 8'h01; b = 8'hFF;
            end
            if (acc == 2) in_valid = 1'b0;
            if (acc == 2 && !busy) done = 1'b1;
        end
        in_valid = 1'b0;
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL b2b_timeout: frames did not finish within 60 cycles");
        end
        checks++;
        if (busy_cyc != 34 || clr_cnt != 2) begin
            failures++;
            $display("FAIL b2b_cycles: busy=%0d clr=%0d want 34 2", busy_cyc, clr_cnt);
        end
        checks++;
        if (acc_on_last != 1) begin
            failures++;
            $display("FAIL b2b_accept_on_last: got %0d want 1", acc_on_last);
        end
        checks++;
        if (xs[0] !== 16'h007F || ys[0] !== 16'hFF80) begin
            failures++;
            $display("FAIL b2b_frame0: x=%h y=%h want 007f ff80", xs[0], ys[0]);
        end
        checks++;
        if (xs[1] !== 16'h0001 || ys[1] !== 16'hFFFF) begin
            failures++;
            $display("FAIL b2b_frame1: x=%h y=%h want 0001 ffff", xs[1], ys[1]);
        end
    endtask

    task automatic test_stall();
        logic [15:0] xs, ys;
        int pos, cyc, stall_left, held, bad_hold, last_cyc;
        xs = '0; ys = '0; pos = 0; cyc = 0; stall_left = 3; held = 0; bad_hold = 0; last_cyc = -1;
        in_valid = 1'b1; a = 8'h55; b = 8'hAA; en = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        while (pos < 16 && cyc < 40) begin
            if (pos == 4 && stall_left > 0) begin
                en = 1'b0; stall_left--;
            end else begin
                en = 1'b1;
            end
            if (pos == 4) begin
                held++;
                if (x !== 1'b1 || y !== 1'b0 || frame_first !== 1'b0 || frame_last !== 1'b0
                    || in_ready !== 1'b0) bad_hold++;
            end
            xs[pos] = x; ys[pos] = y;
            if (frame_last) last_cyc = cyc;
            if (en) pos++;
            cyc++;
            tick();
        end
        en = 1'b1;
        checks++;
        if (held != 4 || bad_hold != 0) begin
            failures++;
            $display("FAIL stall_hold: held=%0d bad=%0d want 4 0", held, bad_hold);
        end
        checks++;
        if (last_cyc != 18) begin
            failures++;
            $display("FAIL stall_last_delay: got %0d want 18", last_cyc);
        end
        checks++;
        if (xs !== 16'h0055 || ys !== 16'hFFAA) begin
            failures++;
            $display("FAIL stall_stream: x=%h y=%h want 0055 ffaa", xs, ys);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL stall_end: busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] xs, ys;
        int last_seen;
        xs = '0; ys = '0; last_seen = 0;
        in_valid = 1'b1; a = 8'h12; b = 8'h34; en = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        for (int i = 0; i < 7; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({busy, in_ready, x, y, frame_last, csa_clr} !== 6'b010000) begin
            failures++;
            $display("FAIL midrst_idle: got %b want 010000",
                     {busy, in_ready, x, y, frame_last, csa_clr});
        end
        for (int i = 0; i < 3; i++) begin
            if (frame_last || csa_clr || busy) last_seen++;
            tick();
        end
        checks++;
        if (last_seen != 0) begin
            failures++;
            $display("FAIL midrst_quiet: got %0d activity cycles want 0", last_seen);
        end
        in_valid = 1'b1; a = 8'h81; b = 8'h02;
        tick();
        in_valid = 1'b0;
        checks++;
        if (csa_clr !== 1'b1) begin
            failures++;
            $display("FAIL midrst_clr: got %b want 1", csa_clr);
        end
        tick();
        for (int i = 0; i < 16; i++) begin
            xs[i] = x; ys[i] = y;
            tick();
        end
        checks++;
        if (xs !== 16'hFF81 || ys !== 16'h0002) begin
            failures++;
            $display("FAIL midrst_new_frame: x=%h y=%h want ff81 0002", xs, ys);
        end
    endtask

    task automatic test_operand_isolation();
        logic [15:0] xs, ys;
        int extra_clr, rdy_seen;
        xs = '0; ys = '0; extra_clr = 0; rdy_seen = 0;
        in_valid = 1'b1; a = 8'h3C; b = 8'hC3; en = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) begin
            if (i == 3) begin
                a = 8'hFF; b = 8'h00; in_valid = 1'b1;
                if (in_ready) rdy_seen++;
            end else begin
                in_valid = 1'b0;
            end
            if (csa_clr) extra_clr++;
            xs[i] = x; ys[i] = y;
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (rdy_seen != 0 || extra_clr != 0) begin
            failures++;
            $display("FAIL iso_no_accept: ready=%0d clr=%0d want 0 0", rdy_seen, extra_clr);
        end
        checks++;
        if (xs !== 16'h003C || ys !== 16'hFFC3) begin
            failures++;
            $display("FAIL iso_stream: x=%h y=%h want 003c ffc3", xs, ys);
        end
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL iso_end: busy=%b rdy=%b want 0 1", busy, in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_back_to_back();
        test_stall();
        test_reset_mid_frame();
        test_operand_isolation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_spm_operand_serializer
